// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one shift-add multiplier between two requesters.
// Requests are granted round-robin, the multiplier gets a single start pulse, and a watchdog aborts a hung multiply.
//
// state | meaning
// IDLE  | no transaction; grant when the multiplier is idle and a request is present
// START | operands latched, mul_St high for this single cycle
// BUSY  | waiting for mul_Done while the watchdog counts towards TMO
module mult_arbiter #(
    parameter int WIDTH = 4,
    parameter int TMO   = 32
) (
    input  logic                 Clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 vld0,
    output logic                 vld1,
    output logic                 err0,
    output logic                 err1,
    output logic [2*WIDTH-1:0]   res0,
    output logic [2*WIDTH-1:0]   res1,
    output logic                 busy,
    output logic                 mul_St,
    output logic [WIDTH-1:0]     mul_A,
    output logic [WIDTH-1:0]     mul_B,
    input  logic                 mul_Idle,
    input  logic                 mul_Done,
    input  logic [2*WIDTH-1:0]   mul_P
);

    localparam int WDW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t           state;
    logic             owner;
    logic             prio;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WDW-1:0]   wd;
    logic             winner;

    // A lone requester wins outright; on a tie the favoured requester wins.
    assign winner = (req0 && req1) ? prio : req1;

    assign mul_A = op_a;
    assign mul_B = op_b;

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            prio   <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            wd     <= '0;
            res0   <= '0;
            res1   <= '0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            vld0   <= 1'b0;
            vld1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            mul_St <= 1'b0;
            busy   <= 1'b0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            vld0   <= 1'b0;
            vld1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            mul_St <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_Idle && (req0 || req1)) begin
                        op_a   <= winner ? a1 : a0;
                        op_b   <= winner ? b1 : b0;
                        owner  <= winner;
                        gnt0   <= !winner;
                        gnt1   <= winner;
                        prio   <= !winner;
                        mul_St <= 1'b1;
                        busy   <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    // Done takes precedence over a watchdog expiry on the same edge.
                    if (mul_Done) begin
                        if (owner) begin
                            res1 <= mul_P;
                            vld1 <= 1'b1;
                        end else begin
                            res0 <= mul_P;
                            vld0 <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wd == WDW'(TMO - 1)) begin
                        err0  <= !owner;
                        err1  <= owner;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: behavioural multiplier with programmable latency/hang,
// round-robin reference model, and per-scenario checks.
module tb_mult_arbiter;

    localparam int W   = 4;
    localparam int TMO = 32;

    logic           Clk = 1'b0;
    logic           rst;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1, vld0, vld1, err0, err1, busy, mul_St;
    logic [2*W-1:0] res0, res1, mul_P;
    logic [W-1:0]   mul_A, mul_B;
    logic           mul_Idle, mul_Done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // behavioural multiplier controls and state
    int             lat        = 6;
    bit             hang       = 1'b0;
    bit             idle_block = 1'b0;
    bit             m_run;
    int             m_cnt;
    logic [2*W-1:0] m_a, m_b;

    // reference model state
    bit             m_prio   = 1'b0;
    logic [2*W-1:0] exp_res0 = '0;
    logic [2*W-1:0] exp_res1 = '0;

    int n_gnt0 = 0, n_gnt1 = 0, n_vld0 = 0, n_vld1 = 0;
    int n_err0 = 0, n_err1 = 0, n_st = 0, n_excl = 0;

    mult_arbiter #(.WIDTH(W), .TMO(TMO)) dut (
        .Clk(Clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .vld0(vld0), .vld1(vld1),
        .err0(err0), .err1(err1),
        .res0(res0), .res1(res1),
        .busy(busy), .mul_St(mul_St),
        .mul_A(mul_A), .mul_B(mul_B),
        .mul_Idle(mul_Idle), .mul_Done(mul_Done), .mul_P(mul_P)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk or posedge rst) begin
        if (rst) begin
            m_run    <= 1'b0;
            m_cnt    <= 0;
            m_a      <= '0;
            m_b      <= '0;
            mul_Done <= 1'b0;
            mul_P    <= '0;
        end else begin
            mul_Done <= 1'b0;
            if (!m_run) begin
                if (mul_St) begin
                    m_run <= 1'b1;
                    m_cnt <= lat;
                    m_a   <= {{W{1'b0}}, mul_A};
                    m_b   <= {{W{1'b0}}, mul_B};
                end
            end else if (!hang) begin
                if (m_cnt <= 1) begin
                    mul_Done <= 1'b1;
                    mul_P    <= m_a * m_b;
                    m_run    <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign mul_Idle = !m_run && !idle_block;

    always @(negedge Clk) begin
        if (!rst) begin
            n_gnt0 += int'(gnt0);
            n_gnt1 += int'(gnt1);
            n_vld0 += int'(vld0);
            n_vld1 += int'(vld1);
            n_err0 += int'(err0);
            n_err1 += int'(err1);
            n_st   += int'(mul_St);
            if (int'(gnt0) + int'(vld0) + int'(err0) > 1 ||
                int'(gnt1) + int'(vld1) + int'(err1) > 1)
                n_excl++;
        end
    end

    task automatic clear_counts();
        n_gnt0 = 0; n_gnt1 = 0; n_vld0 = 0; n_vld1 = 0;
        n_err0 = 0; n_err1 = 0; n_st = 0; n_excl = 0;
    endtask

    task automatic test_reset();
        req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge Clk);
        vectors++;
        if ({gnt0, gnt1, vld0, vld1, err0, err1, mul_St, busy} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {gnt0, gnt1, vld0, vld1, err0, err1, mul_St, busy});
        end
        vectors++;
        if ({res0, res1} !== '0) begin
            miscompares++;
            $display("FAIL reset_res: got res0=%0d res1=%0d expected 0 0", res0, res1);
        end
        vectors++;
        if ({mul_A, mul_B} !== '0) begin
            miscompares++;
            $display("FAIL reset_ops: got mul_A=%0d mul_B=%0d expected 0 0", mul_A, mul_B);
        end
        #1 rst = 1'b0;
        m_prio = 1'b0; exp_res0 = '0; exp_res1 = '0;
        repeat (3) @(negedge Clk);
        vectors++;
        if ({busy, mul_St} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b mul_St=%b expected 0 0", busy, mul_St);
        end
    endtask

    task automatic test_single();
        int t, sc;
        @(negedge Clk); #1;
        clear_counts();
        lat = 6; a0 = 4'd3; b0 = 4'd5; a1 = W'($urandom); b1 = W'($urandom);
        req0 = 1;
        t = 0;
        do begin @(negedge Clk); t++; end while (!gnt0 && t < 20);
        sc = cyc;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_gnt: got gnt0=%b expected 1", gnt0);
        end
        vectors++;
        if ({mul_St, mul_A, mul_B} !== {1'b1, 4'd3, 4'd5}) begin
            miscompares++;
            $display("FAIL single_start: got St=%b A=%0d B=%0d expected 1 3 5", mul_St, mul_A, mul_B);
        end
        m_prio = 1'b1;
        req0 = 0;
        t = 0;
        do begin @(negedge Clk); t++; end while (!vld0 && !err0 && t < 50);
        vectors++;
        if (vld0 !== 1'b1 || res0 !== 8'd15) begin
            miscompares++;
            $display("FAIL single_res: got vld0=%b res0=%0d expected 1 15", vld0, res0);
        end
        vectors++;
        if (cyc - sc != lat + 2) begin
            miscompares++;
            $display("FAIL single_latency: got %0d cycles expected %0d", cyc - sc, lat + 2);
        end
        vectors++;
        if (busy !== 1'b0 || res1 !== 8'd0) begin
            miscompares++;
            $display("FAIL single_after: got busy=%b res1=%0d expected 0 0", busy, res1);
        end
        exp_res0 = 8'd15;
        repeat (3) @(negedge Clk); #1;
        vectors++;
        if (n_gnt0 != 1 || n_st != 1 || n_vld0 != 1 || n_vld1 != 0 || n_gnt1 != 0) begin
            miscompares++;
            $display("FAIL single_pulses: got gnt0=%0d st=%0d vld0=%0d vld1=%0d gnt1=%0d expected 1 1 1 0 0",
                     n_gnt0, n_st, n_vld0, n_vld1, n_gnt1);
        end
    endtask

    task automatic test_alternate();
        int t, k;
        bit gseq[4];
        int gcyc[4];
        bit e;
        req0 = 1; req1 = 1; a0 = 4'd2; b0 = 4'd7; a1 = 4'd4; b1 = 4'd4;
        lat = $urandom_range(1, 6);
        @(negedge Clk); #1 rst = 1'b1;
        repeat (2) @(negedge Clk);
        #1 rst = 1'b0;
        m_prio = 1'b0; exp_res0 = '0; exp_res1 = '0;
        clear_counts();
        k = 0; t = 0;
        while (k < 4 && t < 400) begin
            @(negedge Clk); t++;
            if (gnt0 || gnt1) begin
                gseq[k] = gnt1; gcyc[k] = cyc; k++;
                if (k == 4) begin req0 = 0; req1 = 0; end
            end
        end
        req0 = 0; req1 = 0;
        vectors++;
        if (k != 4) begin
            miscompares++;
            $display("FAIL alt_count: got %0d grants expected 4", k);
        end
        for (int i = 0; i < k; i++) begin
            e = m_prio; m_prio = !e;
            vectors++;
            if (gseq[i] !== e) begin
                miscompares++;
                $display("FAIL alt_order[%0d]: got requester %0d expected %0d", i, gseq[i], e);
            end
        end
        for (int i = 1; i < k; i++) begin
            vectors++;
            if (gcyc[i] - gcyc[i-1] < 4) begin
                miscompares++;
                $display("FAIL alt_spacing[%0d]: got %0d cycles expected >= 4", i, gcyc[i] - gcyc[i-1]);
            end
        end
        t = 0;
        do begin @(negedge Clk); t++; end while (busy && t < 100);
        vectors++;
        if (res0 !== 8'd14 || res1 !== 8'd16) begin
            miscompares++;
            $display("FAIL alt_res: got res0=%0d res1=%0d expected 14 16", res0, res1);
        end
        exp_res0 = 8'd14; exp_res1 = 8'd16;
        @(negedge Clk); #1;
        vectors++;
        if (n_vld0 != 2 || n_vld1 != 2 || n_err0 + n_err1 != 0) begin
            miscompares++;
            $display("FAIL alt_pulses: got vld0=%0d vld1=%0d err=%0d expected 2 2 0", n_vld0, n_vld1, n_err0 + n_err1);
        end
    endtask

    task automatic test_idle_block();
        int t;
        int e;
        @(negedge Clk); #1;
        clear_counts();
        lat = 3; idle_block = 1'b1;
        a1 = W'($urandom); b1 = W'($urandom);
        req0 = 0; req1 = 1;
        repeat (10) @(negedge Clk);
        #1;
        vectors++;
        if (n_gnt1 != 0 || n_st != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_block: got gnt1=%0d st=%0d busy=%b expected 0 0 0", n_gnt1, n_st, busy);
        end
        idle_block = 1'b0;
        @(negedge Clk);
        vectors++;
        if (gnt1 !== 1'b1 || mul_St !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_release: got gnt1=%b mul_St=%b expected 1 1", gnt1, mul_St);
        end
        m_prio = 1'b0;
        req1 = 0;
        t = 0;
        do begin @(negedge Clk); t++; end while (busy && t < 50);
        e = int'(a1) * int'(b1);
        exp_res1 = 8'(e);
        vectors++;
        if (res1 !== exp_res1 || res0 !== exp_res0) begin
            miscompares++;
            $display("FAIL idle_res: got res0=%0d res1=%0d expected %0d %0d", res0, res1, exp_res0, exp_res1);
        end
    endtask

    task automatic test_timeout();
        int t, sc;
        int e;
        @(negedge Clk); #1;
        clear_counts();
        lat = 6; hang = 1'b1;
        a0 = W'($urandom); b0 = W'($urandom);
        req0 = 1;
        t = 0;
        do begin @(negedge Clk); t++; end while (!gnt0 && t < 20);
        sc = cyc;
        m_prio = 1'b1;
        req0 = 0;
        t = 0;
        do begin @(negedge Clk); t++; end while (!err0 && !vld0 && t < 100);
        vectors++;
        if (err0 !== 1'b1 || vld0 !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_err: got err0=%b vld0=%b expected 1 0", err0, vld0);
        end
        vectors++;
        if (cyc - sc != TMO + 1) begin
            miscompares++;
            $display("FAIL tmo_latency: got %0d cycles expected %0d", cyc - sc, TMO + 1);
        end
        vectors++;
        if (res0 !== exp_res0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_state: got res0=%0d busy=%b expected %0d 0", res0, busy, exp_res0);
        end
        hang = 1'b0;
        a1 = W'($urandom); b1 = W'($urandom);
        req1 = 1;
        t = 0;
        do begin @(negedge Clk); t++; end while (!gnt1 && t < 100);
        m_prio = 1'b0;
        req1 = 0;
        t = 0;
        do begin @(negedge Clk); t++; end while (!vld1 && !err1 && t < 100);
        e = int'(a1) * int'(b1);
        exp_res1 = 8'(e);
        vectors++;
        if (vld1 !== 1'b1 || res1 !== exp_res1) begin
            miscompares++;
            $display("FAIL tmo_next: got vld1=%b res1=%0d expected 1 %0d", vld1, res1, exp_res1);
        end
        @(negedge Clk); #1;
        vectors++;
        if (n_err0 != 1 || n_vld0 != 0 || n_excl != 0) begin
            miscompares++;
            $display("FAIL tmo_pulses: got err0=%0d vld0=%0d excl=%0d expected 1 0 0", n_err0, n_vld0, n_excl);
        end
    endtask

    task automatic test_done_at_tmo();
        int t, sc;
        int e;
        @(negedge Clk); #1;
        clear_counts();
        lat = TMO - 1;
        a1 = W'($urandom); b1 = W'($urandom);
        req1 = 1;
        t = 0;
        do begin @(negedge Clk); t++; end while (!gnt1 && t < 20);
        sc = cyc;
        m_prio = 1'b0;
        req1 = 0;
        t = 0;
        do begin @(negedge Clk); t++; end while (!vld1 && !err1 && t < 100);
        e = int'(a1) * int'(b1);
        exp_res1 = 8'(e);
        vectors++;
        if (vld1 !== 1'b1 || err1 !== 1'b0 || res1 !== exp_res1) begin
            miscompares++;
            $display("FAIL edge_done: got vld1=%b err1=%b res1=%0d expected 1 0 %0d", vld1, err1, res1, exp_res1);
        end
        vectors++;
        if (cyc - sc != TMO + 1) begin
            miscompares++;
            $display("FAIL edge_latency: got %0d cycles expected %0d", cyc - sc, TMO + 1);
        end
        // One cycle later than the watchdog allows: abort, then the late Done is ignored.
        @(negedge Clk); #1;
        clear_counts();
        lat = TMO;
        a0 = W'($urandom); b0 = W'($urandom);
        req0 = 1;
        t = 0;
        do begin @(negedge Clk); t++; end while (!gnt0 && t < 20);
        m_prio = 1'b1;
        req0 = 0;
        t = 0;
        do begin @(negedge Clk); t++; end while (!vld0 && !err0 && t < 100);
        vectors++;
        if (err0 !== 1'b1 || vld0 !== 1'b0) begin
            miscompares++;
            $display("FAIL late_done_err: got err0=%b vld0=%b expected 1 0", err0, vld0);
        end
        repeat (4) @(negedge Clk);
        #1;
        vectors++;
        if (n_vld0 != 0 || n_err0 != 1 || res0 !== exp_res0) begin
            miscompares++;
            $display("FAIL late_done_ignored: got vld0=%0d err0=%0d res0=%0d expected 0 1 %0d", n_vld0, n_err0, res0, exp_res0);
        end
    endtask

    task automatic test_reset_mid_busy();
        int t;
        int e;
        @(negedge Clk); #1;
        lat = 20;
        a0 = W'($urandom); b0 = W'($urandom);
        req0 = 1;
        t = 0;
        do begin @(negedge Clk); t++; end while (!gnt0 && t < 20);
        req0 = 0;
        repeat (5) @(negedge Clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({gnt0, gnt1, vld0, vld1, err0, err1, mul_St, busy} !== 8'b0 || {res0, res1, mul_A, mul_B} !== '0) begin
            miscompares++;
            $display("FAIL midrst_clear: got ctrl=%b res0=%0d res1=%0d A=%0d B=%0d expected all 0",
                     {gnt0, gnt1, vld0, vld1, err0, err1, mul_St, busy}, res0, res1, mul_A, mul_B);
        end
        repeat (2) @(negedge Clk);
        #1 rst = 1'b0;
        m_prio = 1'b0; exp_res0 = '0; exp_res1 = '0;
        clear_counts();
        repeat (40) @(negedge Clk);
        #1;
        vectors++;
        if (n_vld0 + n_vld1 + n_err0 + n_err1 != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_quiet: got vld/err pulses=%0d busy=%b expected 0 0", n_vld0 + n_vld1 + n_err0 + n_err1, busy);
        end
        lat = 4;
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        req0 = 1; req1 = 1;
        t = 0;
        do begin @(negedge Clk); t++; end while (!gnt0 && !gnt1 && t < 20);
        vectors++;
        if ({gnt0, gnt1} !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst_prio: got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
        end
        m_prio = 1'b1;
        req0 = 0; req1 = 0;
        t = 0;
        do begin @(negedge Clk); t++; end while (busy && t < 50);
        e = int'(a0) * int'(b0);
        exp_res0 = 8'(e);
        vectors++;
        if (res0 !== exp_res0) begin
            miscompares++;
            $display("FAIL midrst_res: got res0=%0d expected %0d", res0, exp_res0);
        end
    endtask

    task automatic test_random();
        int t, r, e;
        bit w;
        @(negedge Clk); #1;
        clear_counts();
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            req0 = r[0]; req1 = r[1];
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            lat = $urandom_range(1, 10);
            t = 0;
            do begin @(negedge Clk); t++; end while (!gnt0 && !gnt1 && t < 20);
            w = (req0 && req1) ? m_prio : req1;
            m_prio = !w;
            vectors++;
            if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01) || {mul_A, mul_B} !== (w ? {a1, b1} : {a0, b0})) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: got gnt1=%b gnt0=%b A=%0d B=%0d expected winner %0d", i, gnt1, gnt0, mul_A, mul_B, w);
            end
            req0 = 0; req1 = 0;
            t = 0;
            do begin @(negedge Clk); t++; end while (busy && t < 40);
            if (w) begin
                e = int'(a1) * int'(b1);
                exp_res1 = 8'(e);
            end else begin
                e = int'(a0) * int'(b0);
                exp_res0 = 8'(e);
            end
            vectors++;
            if (res0 !== exp_res0 || res1 !== exp_res1) begin
                miscompares++;
                $display("FAIL rand_res[%0d]: got res0=%0d res1=%0d expected %0d %0d", i, res0, res1, exp_res0, exp_res1);
            end
        end
        @(negedge Clk); #1;
        vectors++;
        if (n_vld0 + n_vld1 != 40 || n_err0 + n_err1 != 0 || n_excl != 0) begin
            miscompares++;
            $display("FAIL rand_pulses: got vld=%0d err=%0d excl=%0d expected 40 0 0", n_vld0 + n_vld1, n_err0 + n_err1, n_excl);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_idle_block();
        test_timeout();
        test_done_at_tmo();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
